// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment scanner with shadow
// registers, leading-zero blanking and selectable output polarity.
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit LZ_BLANK    = 1'b1,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int PW = $clog2(REFRESH_DIV)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx
);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] sval_q, sval_d;
  logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [IW-1:0]           didx_q, didx_d;

  logic                    wrap;
  logic                    allz;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [3:0]              nib;

  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] g;
    unique case (n)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      4'hF: g = 7'b1000111;
    endcase
    return g;
  endfunction

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    sval_d  = sval_q;
    sdp_d   = sdp_q;
    wrap    = (presc_q == PW'(REFRESH_DIV - 1));
    if (wrap) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    if (load) begin
      sval_d = value;
      sdp_d  = dp_in;
    end
  end

  // a digit is leading-zero blank when it and everything above it is zero
  always_comb begin
    allz    = 1'b1;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      allz       = allz & (sval_q[4*i +: 4] == 4'd0);
      lz_mask[i] = allz & (i != 0) & LZ_BLANK;
    end
  end

  always_comb begin
    nib    = sval_q[{idx_q, 2'b00} +: 4];
    seg_d  = font(nib);
    dp_d   = sdp_q[idx_q];
    an_d   = '0;
    didx_d = idx_q;
    an_d[idx_q] = 1'b1;
    if (lz_mask[idx_q]) seg_d = '0;
    if (blank) begin
      seg_d = '0;
      dp_d  = 1'b0;
      an_d  = '0;
    end
  end

  // output registers hold the final pin polarity
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
      sval_q  <= '0;
      sdp_q   <= '0;
      seg_q   <= {7{ACTIVE_LOW}};
      dp_q    <= ACTIVE_LOW;
      an_q    <= {NUM_DIGITS{ACTIVE_LOW}};
      didx_q  <= '0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sval_q  <= sval_d;
      sdp_q   <= sdp_d;
      seg_q   <= seg_d ^ {7{ACTIVE_LOW}};
      dp_q    <= dp_d ^ ACTIVE_LOW;
      an_q    <= an_d ^ {NUM_DIGITS{ACTIVE_LOW}};
      didx_q  <= didx_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign digit_idx = didx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: three polarity/blanking variants checked
// against an arithmetic display model plus hand-computed pins.
module tb_seg_scan_driver;
  localparam int N   = 4;
  localparam int DIV = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load, blank;
  logic [15:0] value;
  logic [3:0]  dp_in;

  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic [3:0] an_a, an_b, an_c;
  logic [1:0] di_a, di_b, di_c;

  seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV),
    .ACTIVE_LOW(1'b0), .LZ_BLANK(1'b1)) dut_a (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
    .load(load), .blank(blank), .seg(seg_a), .dp(dp_a),
    .an(an_a), .digit_idx(di_a));

  seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV),
    .ACTIVE_LOW(1'b0), .LZ_BLANK(1'b0)) dut_b (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
    .load(load), .blank(blank), .seg(seg_b), .dp(dp_b),
    .an(an_b), .digit_idx(di_b));

  seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV),
    .ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1)) dut_c (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in),
    .load(load), .blank(blank), .seg(seg_c), .dp(dp_c),
    .an(an_c), .digit_idx(di_c));

  localparam logic [6:0] FONT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  // expected {seg,dp,an} for digit d of the shadow contents
  function automatic logic [11:0] model(input bit al, input bit lz,
      input logic [15:0] v, input logic [3:0] dpv,
      input int d, input logic blk);
    logic [6:0] s;
    logic       p;
    logic [3:0] a;
    if (blk) begin
      s = '0;
      p = 1'b0;
      a = '0;
    end else begin
      a = 4'(1 << d);
      p = dpv[d];
      if (lz && d > 0 && (v >> (4 * d)) == 16'd0) s = '0;
      else s = FONT[v[4*d +: 4]];
    end
    if (al) return ~{s, p, a};
    return {s, p, a};
  endfunction

  int unsigned m_n;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_ok = 1'b0;
  logic [11:0] e_a, e_b, e_c;
  logic [1:0]  e_idx;

  always @(posedge clk) begin
    if (rst) begin
      m_n   <= 0;
      m_val <= '0;
      m_dp  <= '0;
      m_ok  <= 1'b1;
      e_a   <= model(1'b0, 1'b1, 16'd0, 4'd0, 0, 1'b1);
      e_b   <= model(1'b0, 1'b0, 16'd0, 4'd0, 0, 1'b1);
      e_c   <= model(1'b1, 1'b1, 16'd0, 4'd0, 0, 1'b1);
      e_idx <= '0;
    end else begin
      e_a   <= model(1'b0, 1'b1, m_val, m_dp, (m_n / DIV) % N, blank);
      e_b   <= model(1'b0, 1'b0, m_val, m_dp, (m_n / DIV) % N, blank);
      e_c   <= model(1'b1, 1'b1, m_val, m_dp, (m_n / DIV) % N, blank);
      e_idx <= 2'((m_n / DIV) % N);
      m_n   <= m_n + 1;
      if (load) begin
        m_val <= value;
        m_dp  <= dp_in;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  logic        lit_en = 1'b0;
  string       lit_name;
  int          lit_sel;
  logic [11:0] lit_exp;

  function automatic logic [11:0] lit_act(input int sel);
    case (sel)
      0: return {5'd0, seg_a};
      1: return {8'd0, an_a};
      2: return {11'd0, dp_a};
      3: return {10'd0, di_a};
      4: return {5'd0, seg_b};
      5: return {5'd0, seg_c};
      6: return {8'd0, an_c};
      default: return 12'hFFF;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [11:0] act,
      input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("a_out", {seg_a, dp_a, an_a}, e_a);
      chk("b_out", {seg_b, dp_b, an_b}, e_b);
      chk("c_out", {seg_c, dp_c, an_c}, e_c);
      chk("a_idx", {10'd0, di_a}, {10'd0, e_idx});
      chk("b_idx", {10'd0, di_b}, {10'd0, e_idx});
      chk("c_idx", {10'd0, di_c}, {10'd0, e_idx});
      chk("a_onehot", 12'($countones(an_a) <= 1), 12'd1);
      chk("c_onehot", 12'($countones(~an_c) <= 1), 12'd1);
      if (lit_en) chk(lit_name, lit_act(lit_sel), lit_exp);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input int sel,
      input logic [11:0] ex);
    lit_name = nm;
    lit_sel  = sel;
    lit_exp  = ex;
    lit_en   = 1'b1;
    @(negedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    blank = 1'b0;
    value = '0;
    dp_in = '0;
    cyc(3);
    rst = 1'b0;
    pin("rel_seg", 0, 12'b1111110);
    pin("rel_an", 1, 12'b0001);
    cyc(2);
    pin("scan1_an", 1, 12'b0010);
    pin("scan1_idx", 3, 12'd1);
    cyc(2);
    pin("scan2_an", 1, 12'b0100);
    cyc(3);
    pin("scan3_an", 1, 12'b1000);
    cyc(3);
    pin("scan0_an", 1, 12'b0001);

    value = 16'h00A7;
    dp_in = 4'b0010;
    load  = 1'b1;
    cyc(1);
    load = 1'b0;
    pin("a7_d0_seg", 0, 12'b1110000);
    cyc(2);
    pin("a7_d1_seg", 0, 12'b1110111);
    pin("a7_d1_dp", 2, 12'd1);
    cyc(1);
    pin("a7_d2_lz", 0, 12'd0);
    pin("a7_d2_dp", 2, 12'd0);
    pin("a7_d2_nolz", 4, 12'b1111110);
    cyc(5);

    value = 16'hF0F0;
    dp_in = 4'b0000;
    load  = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(3);
    pin("f0_d1_seg", 4, 12'b1000111);
    cyc(3);
    pin("f0_d2_inner0", 0, 12'b1111110);
    cyc(7);

    value = 16'h0008;
    load  = 1'b1;
    cyc(1);
    load = 1'b0;
    pin("al_d0_seg", 5, 12'd0);
    pin("al_d0_an", 6, 12'b1110);
    cyc(9);
    pin("al_d3_lz", 5, 12'b1111111);

    blank = 1'b1;
    pin("blank_an", 1, 12'd0);
    pin("blank_seg", 0, 12'd0);
    cyc(4);
    blank = 1'b0;
    pin("unblank_an", 1, 12'b0001);
    cyc(7);

    rst   = 1'b1;
    load  = 1'b1;
    value = 16'hFFFF;
    dp_in = 4'hF;
    pin("midrst_an", 1, 12'd0);
    rst  = 1'b0;
    load = 1'b0;
    pin("postrst_seg", 0, 12'b1111110);
    pin("postrst_dp", 2, 12'd0);
    cyc(1);

    value = 16'h1234;
    dp_in = 4'b0000;
    load  = 1'b1;
    cyc(1);
    load = 1'b0;
    pin("wrapload_seg", 0, 12'b1111001);
    cyc(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: digit count, legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clocks per digit slot, legal range >=2.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 = seg, dp and an driven active-low; 0 = active-high.
REQ-004 Parameter LZ_BLANK, default 1: 1 = leading-zero blanking enabled.
REQ-005 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  reset, synchronous and active-high.
REQ-007 Port value  input  4*NUM_DIGITS  hex digits; nibble i = digit i, with digit 0 the least significant (rightmost).
REQ-008 Port dp_in  input  NUM_DIGITS  decimal-point request; bit i = digit i.
REQ-009 Port load  input  1  capture value and dp_in into the shadow registers.
REQ-010 Port blank  input  1  level; forces the whole display dark.
REQ-011 Port seg  output  7  segments {a,b,c,d,e,f,g}, bit 6 = a.
REQ-012 Port dp  output  1  decimal-point segment.
REQ-013 Port an  output  NUM_DIGITS  digit enables, one-hot (active level per ACTIVE_LOW).
REQ-014 Port digit_idx  output  clog2(NUM_DIGITS), minimum 1 bit  index of the digit currently driven on an.

Function
REQ-015 Prescaler shall count 0..REFRESH_DIV-1 and wrap to 0; the scan index shall advance by 1 in the cycle the prescaler wraps.
REQ-016 Scan index shall wrap from NUM_DIGITS-1 to 0; with NUM_DIGITS=1 it shall stay at 0.
REQ-017 When load=1 at an edge, shadow_val<=value and shadow_dp<=dp_in at that edge.
REQ-018 seg, dp, an and digit_idx shall be registered: they reflect the scan index and shadow state present before the same edge (1-cycle latency).
REQ-019 Active-high font {a..g}: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-020 Leading-zero blanking: with LZ_BLANK=1, digit i>0 is blank when shadow nibbles NUM_DIGITS-1 down to i are all zero; digit 0 is never zero-blanked.
REQ-021 A blanked digit shall drive seg all off, with its an still asserted; dp follows shadow_dp[i] even on a blanked digit.
REQ-022 blank=1 shall drive all an inactive, seg all off and dp off on the next edge; the prescaler and scan index keep running.
REQ-023 With ACTIVE_LOW=1, seg, dp and an are the bitwise inverse of the active-high encoding; digit_idx is never inverted.
REQ-024 When load and the prescaler wrap occur in the same cycle, both shall take effect; the next output reflects the new index with the new shadow data.
REQ-025 an shall never have more than one digit active in any cycle.

Reset
REQ-026 While rst=1: prescaler=0, scan index=0, shadow_val=0, shadow_dp=0, an all inactive, seg all off, dp off, digit_idx=0; load is ignored.
REQ-027 On the first edge after rst falls, outputs shall show digit 0 with glyph "0" (seg=1111110 active-high) and dp off.
REQ-028 Reset asserted mid-scan shall take effect on the next edge regardless of prescaler or index state.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0, LZ_BLANK=1 unless stated)
REQ-029 Release rst, hold load=0 -> an=0001, seg=1111110; an steps 0010, 0100, 1000, 0001 every 4 clocks, with digit_idx 1, 2, 3, 0.
REQ-030 Load value=16'h00A7, dp_in=4'b0010 -> digit0 seg=1110000; digit1 seg=1110111, dp=1; digits 2 and 3 seg=0000000, dp=0.
REQ-031 Load value=16'hF0F0 with LZ_BLANK=0 -> digits 0 and 2 seg=1111110; digits 1 and 3 seg=1000111.
REQ-032 blank=1 for 6 clocks, then blank=0 -> an=0000, seg=0, dp=0 during blank; scan resumes at index (prior+1 or +2 per elapsed wraps), with no restart.
REQ-033 ACTIVE_LOW=1, load 16'h0008 -> digit0 seg=0000000, an=1110; digit 3 blanked, seg=1111111.
REQ-034 Assert rst for 1 clock when index=2 and prescaler=3 -> next edge: an inactive, shadow cleared; after release, digit0 shows "0".
